// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared mode encodings and field widths for the immediate
//                generation pipe.
//  Revision    : 1.0
// ============================================================================
package imm_pkg;

    localparam logic [2:0] MODE_SIMM13 = 3'b000;
    localparam logic [2:0] MODE_DISP22 = 3'b001;
    localparam logic [2:0] MODE_DISP30 = 3'b010;
    localparam logic [2:0] MODE_SETHI  = 3'b011;
    localparam logic [2:0] MODE_PASS   = 3'b100;
    localparam logic [2:0] MODE_UIMM13 = 3'b101;

    localparam int c_simm13_w = 13;
    localparam int c_disp22_w = 22;
    localparam int c_disp30_w = 30;

endpackage
`default_nettype wire

// File: rtl/imm_extract_core.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extract_core
//  Description : Combinational field select and sign/zero extension of an
//                instruction word to DATA_W bits.
//  Revision    : 1.0
// ============================================================================
module imm_extract_core
    import imm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       i_ir,
    input  logic [2:0]        i_mode,
    output logic [DATA_W-1:0] o_imm,
    output logic              o_illegal
);

    // Size casts of signed operands sign-extend; shifts happen at DATA_W.
    always_comb begin
        o_imm     = '0;
        o_illegal = 1'b0;
        case (i_mode)
            MODE_SIMM13: o_imm = DATA_W'($signed(i_ir[c_simm13_w-1:0]));
            MODE_DISP22: o_imm = DATA_W'($signed(i_ir[c_disp22_w-1:0])) << 2;
            MODE_DISP30: o_imm = DATA_W'($signed(i_ir[c_disp30_w-1:0])) << 2;
            MODE_SETHI:  o_imm = DATA_W'({i_ir[c_disp22_w-1:0], 10'b0});
            MODE_PASS:   o_imm = DATA_W'($signed(i_ir));
            MODE_UIMM13: o_imm = DATA_W'(i_ir[c_simm13_w-1:0]);
            default:     o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extend_pipe
//  Description : Two-stage valid/ready immediate generator between IR decode
//                and the ALU B-operand / branch-target adder.
//  Revision    : 1.0
// ============================================================================
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_OUT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_ir,
    input  logic [2:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_illegal
);

    logic              r_s1_valid;
    logic [31:0]       r_s1_ir;
    logic [2:0]        r_s1_mode;
    logic [DATA_W-1:0] w_imm;
    logic              w_illegal;
    logic              w_s2_adv;
    logic              w_s1_adv;

    assign w_s2_adv = !out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // Data registers only load on a real transfer so idle bus values never leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_ir    <= '0;
            r_s1_mode  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ir   <= in_ir;
                r_s1_mode <= in_mode;
            end
        end
    end

    imm_extract_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .i_ir      (r_s1_ir),
        .i_mode    (r_s1_mode),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic              r_out_valid;
            logic [DATA_W-1:0] r_out_imm;
            logic              r_out_illegal;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_out_valid   <= 1'b0;
                    r_out_imm     <= '0;
                    r_out_illegal <= 1'b0;
                end else if (w_s2_adv) begin
                    r_out_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_out_imm     <= w_imm;
                        r_out_illegal <= w_illegal;
                    end
                end
            end

            assign out_valid   = r_out_valid;
            assign out_imm     = r_out_imm;
            assign out_illegal = r_out_illegal;
        end else begin : g_comb_out
            assign out_valid   = r_s1_valid;
            assign out_imm     = w_imm;
            assign out_illegal = w_illegal;
        end
    endgenerate

endmodule
`default_nettype wire
